// File: rtl/ahbl_apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge.
package ahbl_apb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StSetup,
    StAccess,
    StDone,
    StErr1,
    StErr2
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Storage width of the slot index; a single slot still needs a 1-bit vector.
  function automatic int unsigned slot_idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_slot_decoder.sv
// Slot index to one-hot select, range check and per-slot return-path mux.
module apb_slot_decoder
  import ahbl_apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SLOTS  = 16,
  parameter int unsigned IDX_WIDTH  = slot_idx_width(NUM_SLOTS)
) (
  input  logic [IDX_WIDTH-1:0]            slot_idx,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0] prdata_all,
  input  logic [NUM_SLOTS-1:0]            pready_all,
  input  logic [NUM_SLOTS-1:0]            pslverr_all,
  output logic [NUM_SLOTS-1:0]            onehot,
  output logic                            in_range,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            ready,
  output logic                            err
);

  // Out-of-range indices match no slot, so select and return path stay zero.
  always_comb begin
    onehot   = '0;
    rdata    = '0;
    ready    = 1'b0;
    err      = 1'b0;
    in_range = 32'(slot_idx) < NUM_SLOTS;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (32'(slot_idx) == s) begin
        onehot[s] = 1'b1;
        rdata     = prdata_all[s*DATA_WIDTH +: DATA_WIDTH];
        ready     = pready_all[s];
        err       = pslverr_all[s];
      end
    end
  end

endmodule

// File: rtl/ahbl_apb_bridge_nslot.sv
// AHB-Lite slave to multi-slot APB master bridge with optional PREADY timeout.
module ahbl_apb_bridge_nslot
  import ahbl_apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned NUM_SLOTS      = 16,
  parameter int unsigned SLOT_LSB       = 24,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                            HCLK,
  input  logic                            HRESETN,
  input  logic                            HSEL,
  input  logic [ADDR_WIDTH-1:0]           HADDR,
  input  logic [1:0]                      HTRANS,
  input  logic                            HWRITE,
  input  logic [2:0]                      HSIZE,
  input  logic [DATA_WIDTH-1:0]           HWDATA,
  input  logic                            HREADYIN,
  output logic                            HREADYOUT,
  output logic [DATA_WIDTH-1:0]           HRDATA,
  output logic                            HRESP,
  output logic [NUM_SLOTS-1:0]            PSEL,
  output logic [ADDR_WIDTH-1:0]           PADDR,
  output logic                            PWRITE,
  output logic                            PENABLE,
  output logic [DATA_WIDTH-1:0]           PWDATA,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLOTS-1:0]            PREADY,
  input  logic [NUM_SLOTS-1:0]            PSLVERR
);

  localparam int unsigned IdxW   = slot_idx_width(NUM_SLOTS);
  localparam int unsigned CntW   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CntLim = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         slot_q, slot_d, haddr_idx;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d, hrdata_q, hrdata_d;
  logic                    accept, haddr_ok;
  logic [NUM_SLOTS-1:0]    slot_onehot;
  logic                    slot_valid, sel_ready, sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    unused_ahb;

  assign unused_ahb = ^{HSIZE, HTRANS[0]};

  if (NUM_SLOTS > 1) begin : g_idx
    assign haddr_idx = HADDR[SLOT_LSB +: IdxW];
  end else begin : g_idx_single
    assign haddr_idx = '0;
  end

  assign accept   = HSEL & HREADYIN & HTRANS[1];
  assign haddr_ok = 32'(haddr_idx) < NUM_SLOTS;

  apb_slot_decoder #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_SLOTS  (NUM_SLOTS),
    .IDX_WIDTH  (IdxW)
  ) u_dec (
    .slot_idx    (slot_q),
    .prdata_all  (PRDATA),
    .pready_all  (PREADY),
    .pslverr_all (PSLVERR),
    .onehot      (slot_onehot),
    .in_range    (slot_valid),
    .rdata       (sel_rdata),
    .ready       (sel_ready),
    .err         (sel_err)
  );

  // Next-state logic: transfer sequencing, latching and timeout counting.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    unique case (state_q)
      StIdle, StDone, StErr2: begin
        if (accept) begin
          slot_d   = haddr_idx;
          paddr_d  = HADDR;
          pwrite_d = HWRITE;
          // Writes always take the data phase first; the slot is checked there.
          if (HWRITE)        state_d = StWdata;
          else if (haddr_ok) state_d = StSetup;
          else               state_d = StErr1;
        end else begin
          state_d = StIdle;
        end
      end
      StWdata: begin
        pwdata_d = HWDATA;
        state_d  = slot_valid ? StSetup : StErr1;
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        if (sel_ready) begin
          if (sel_err) begin
            state_d = StErr1;
          end else begin
            if (!pwrite_q) hrdata_d = sel_rdata;
            state_d = StDone;
          end
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CntW'(CntLim)) begin
          state_d = StErr1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q  <= StIdle;
      slot_q   <= '0;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
    end
  end

  // State-decoded bus outputs.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    PENABLE   = 1'b0;
    PSEL      = '0;
    unique case (state_q)
      StWdata: HREADYOUT = 1'b0;
      StSetup: begin
        HREADYOUT = 1'b0;
        PSEL      = slot_onehot;
      end
      StAccess: begin
        HREADYOUT = 1'b0;
        PSEL      = slot_onehot;
        PENABLE   = 1'b1;
      end
      StErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      StErr2:  HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  assign PADDR  = paddr_q;
  assign PWRITE = pwrite_q;
  assign PWDATA = pwdata_q;
  assign HRDATA = hrdata_q;

endmodule
